// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_WAIT_HI = 2'd2,
    ST_WAIT_LO = 2'd3
  } sched_state_t;

  localparam int TIMEOUT_DEFAULT = 65535;
  localparam int GID_W           = 3;
  localparam int TO_W            = 16;

  function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] v);
    return (v == '1) ? v : v + TO_W'(1);
  endfunction

endpackage

// File: rtl/uart_rr_arb.sv
// Combinational round-robin picker: the first requester after last_grant wins.
module uart_rr_arb import uart_pkg::*; #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  req,
  input  logic [GID_W-1:0] last_grant,
  output logic [NREQ-1:0]  gnt,
  output logic [GID_W-1:0] idx,
  output logic             any
);

  logic [GID_W-1:0]  start;
  logic [2*NREQ-1:0] dbl;
  logic [2*NREQ-1:0] shifted;
  logic [NREQ-1:0]   rot;
  int                win;

  always_comb begin
    gnt     = '0;
    idx     = last_grant;
    any     = 1'b0;
    win     = 0;
    start   = (last_grant == GID_W'(NREQ-1)) ? '0 : last_grant + GID_W'(1);
    dbl     = {req, req};
    // rot[j] is the request at position start+j, modulo NREQ
    shifted = dbl >> start;
    rot     = shifted[NREQ-1:0];
    for (int j = 0; j < NREQ; j++) begin
      if (!any && rot[j]) begin
        any = 1'b1;
        win = int'(start) + j;
      end
    end
    if (win >= NREQ) win = win - NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (any && win == i) gnt[i] = 1'b1;
    end
    if (any) idx = GID_W'(win);
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Multiplexes per-requester byte streams onto one UART transmitter with
// round-robin packet arbitration, burst limiting and a load timeout.
//
//   state      | meaning
//   IDLE       | no owner; arbitrate and latch the winner's first byte
//   LOAD       | tx_load held until the UART reports busy
//   WAIT_HI    | same as LOAD, for follow-on bytes of the same owner
//   WAIT_LO    | UART busy; on completion continue the packet or release
module uart_tx_sched import uart_pkg::*; #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int MAXBURST = 16,
  parameter int TIMEOUT  = TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  output logic [WIDTH-1:0]      tx_data,
  output logic                  tx_load,
  input  logic                  tx_busy,
  output logic [2:0]            grant_id,
  output logic                  sched_active,
  output logic                  timeout_err,
  input  logic                  err_clr
);

  localparam logic [TO_W-1:0]  TO_LIM    = TO_W'(TIMEOUT-1);
  localparam logic [TO_W-1:0]  BURST_LIM = TO_W'(MAXBURST);
  localparam logic [GID_W-1:0] LAST_RST  = GID_W'(NREQ-1);

  sched_state_t     state_q, state_d;
  logic [WIDTH-1:0] tx_data_q, tx_data_d;
  logic [GID_W-1:0] grant_q, grant_d;
  logic [GID_W-1:0] last_q, last_d;
  logic [TO_W-1:0]  burst_q, burst_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [TO_W-1:0]  burst_inc;
  logic             err_q, err_d;
  logic             lastf_q, lastf_d;
  logic [NREQ-1:0]  ready_c;
  logic             load_c;
  logic             timeout_hit;

  logic [NREQ-1:0]  arb_gnt;
  logic [GID_W-1:0] arb_idx;
  logic             arb_any;
  logic [WIDTH-1:0] arb_data;
  logic             arb_last;

  logic [NREQ-1:0]  own_onehot;
  logic             own_valid;
  logic             own_last;
  logic [WIDTH-1:0] own_data;

  uart_rr_arb #(.NREQ(NREQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_q),
    .gnt        (arb_gnt),
    .idx        (arb_idx),
    .any        (arb_any)
  );

  always_comb begin
    arb_data   = '0;
    arb_last   = 1'b0;
    own_onehot = '0;
    own_valid  = 1'b0;
    own_last   = 1'b0;
    own_data   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        arb_data = req_data[i*WIDTH +: WIDTH];
        arb_last = req_last[i];
      end
      if (grant_q == GID_W'(i)) begin
        own_onehot[i] = 1'b1;
        own_valid     = req_valid[i];
        own_last      = req_last[i];
        own_data      = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign burst_inc = burst_q + TO_W'(1);

  always_comb begin
    state_d     = state_q;
    tx_data_d   = tx_data_q;
    grant_d     = grant_q;
    last_d      = last_q;
    burst_d     = burst_q;
    to_d        = '0;
    err_d       = err_q;
    lastf_d     = lastf_q;
    ready_c     = '0;
    load_c      = 1'b0;
    timeout_hit = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          ready_c   = arb_gnt;
          tx_data_d = arb_data;
          lastf_d   = arb_last;
          grant_d   = arb_idx;
          burst_d   = '0;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD, ST_WAIT_HI: begin
        // tx_load drops in the same cycle busy is seen, not one cycle later
        load_c = ~tx_busy;
        if (tx_busy) begin
          state_d = ST_WAIT_LO;
        end else if (to_q >= TO_LIM) begin
          timeout_hit = 1'b1;
          last_d      = grant_q;
          state_d     = ST_IDLE;
        end else begin
          to_d = sat_inc(to_q);
        end
      end
      ST_WAIT_LO: begin
        if (!tx_busy) begin
          burst_d = burst_inc;
          if (!lastf_q && burst_inc < BURST_LIM && own_valid) begin
            ready_c   = own_onehot;
            tx_data_d = own_data;
            lastf_d   = own_last;
            state_d   = ST_WAIT_HI;
          end else begin
            last_d  = grant_q;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (timeout_hit)  err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tx_data_q <= '0;
      grant_q   <= '0;
      last_q    <= LAST_RST;
      burst_q   <= '0;
      to_q      <= '0;
      err_q     <= 1'b0;
      lastf_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      burst_q   <= burst_d;
      to_q      <= to_d;
      err_q     <= err_d;
      lastf_q   <= lastf_d;
    end
  end

  assign req_ready    = ready_c & {NREQ{~rst}};
  assign tx_load      = load_c & ~rst;
  assign tx_data      = tx_data_q;
  assign grant_id     = grant_q;
  assign timeout_err  = err_q;
  assign sched_active = (state_q != ST_IDLE);

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 8, byte width.
REQ-003 SHALL have parameter MAXBURST, default 16, max bytes per grant before forced re-arbitration.
REQ-004 SHALL have parameter TIMEOUT, default 65535, cycles allowed for tx_busy to rise after load.
REQ-005 SHALL have ports as follows; one clock; reset is synchronous and active-high:
- clk  in  1  sole clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  per-requester byte valid.
- req_data  in  NREQ*WIDTH  per-requester byte; requester i at bits [i*WIDTH +: WIDTH].
- req_last  in  NREQ  byte is last of the requester's packet.
- req_ready  out  NREQ  byte accepted (one-hot, 1-cycle pulse).
- tx_data  out  WIDTH  byte to UART transmitter.
- tx_load  out  1  load request to UART, level.
- tx_busy  in  1  UART transmit-in-progress.
- grant_id  out  3  index of current owner.
- sched_active  out  1  a grant is held.
- timeout_err  out  1  sticky: busy never rose.
- err_clr  in  1  clears timeout_err.

Function
REQ-006 SHALL implement FSM states IDLE, LOAD, WAIT_HI, WAIT_LO.
REQ-007 IDLE: if any req_valid, SHALL grant by round-robin from the index after last_grant (wrapping NREQ-1 to 0), latch req_data of the winner into tx_data, pulse req_ready[winner], clear burst_cnt, then go to LOAD next cycle.
REQ-008 LOAD: SHALL hold tx_load=1 and tx_data stable; on tx_busy=1 SHALL deassert tx_load and go to WAIT_LO; else increment to_cnt.
REQ-009 SHALL treat WAIT_HI as the state entered from WAIT_LO when the same owner continues (see REQ-011); WAIT_HI behaves identically to LOAD. This covers the UART sampling load only on its baud tick.
REQ-010 WAIT_LO: SHALL wait for tx_busy=0, then increment burst_cnt.
REQ-011 After REQ-010, if last byte had req_last=0, burst_cnt<MAXBURST, and req_valid[owner]=1: SHALL accept the next byte from the same owner (req_ready pulse, latch) and enter WAIT_HI. Otherwise SHALL update last_grant=owner and return to IDLE.
REQ-012 If owner's req_valid=0 mid-packet at REQ-011, SHALL release the grant (no wait).
REQ-013 In LOAD/WAIT_HI, if to_cnt reaches TIMEOUT: SHALL set timeout_err, drop tx_load, release grant, return to IDLE. The byte is lost.
REQ-014 to_cnt SHALL be 16 bits, cleared on each state entry, saturating.
REQ-015 req_ready SHALL be one-hot or zero, and SHALL assert only in the cycle data is latched.
REQ-016 sched_active SHALL be 1 in every state except IDLE; grant_id SHALL hold its last value in IDLE.
REQ-017 err_clr SHALL clear timeout_err unless a timeout sets it in the same cycle; set wins.
REQ-018 A requester whose req_valid drops without ready SHALL NOT be granted (no request latching).

Reset
REQ-019 rst SHALL force: state IDLE, tx_load 0, tx_data 0, req_ready 0, grant_id 0, last_grant NREQ-1 (so requester 0 wins first), burst_cnt 0, to_cnt 0, timeout_err 0, sched_active 0.
REQ-020 rst mid-transfer SHALL abandon the byte; no req_ready pulse in the reset cycle.

Structure
REQ-021 State encoding and the default of TIMEOUT SHALL live in shared package uart_pkg.
REQ-022 The round-robin priority picker SHALL be sub-module uart_rr_arb (combinational, inputs request vector and last_grant, output one-hot plus index).

Verification
REQ-023 After reset, req_valid=4'b1111, single-byte packets (req_last=1): grants SHALL be 0,1,2,3,0 in order, one tx_load per byte.
REQ-024 Requester 2 sends packet 0x41,0x42,0x43 (last on 0x43) while requester 1 is valid: all three bytes SHALL go out consecutively before grant_id=1.
REQ-025 Requester 0 sends a 20-byte packet with MAXBURST=16 while requester 3 is valid: after byte 16, grant SHALL pass to 3, then return to 0 for bytes 17..20.
REQ-026 Model tx_busy rising 5 cycles after tx_load: tx_load SHALL stay high exactly those 5 cycles, and tx_data SHALL be stable throughout.
REQ-027 Hold tx_busy=0 with TIMEOUT=100: timeout_err SHALL set after 100 cycles in LOAD, the FSM SHALL return to IDLE, and err_clr SHALL clear timeout_err next cycle.
REQ-028 Assert rst during WAIT_LO: all outputs SHALL take reset values next cycle, and the next grant SHALL go to requester 0.
